// File: rtl/bus_reg_file.sv
// bus_reg_file: DEPTH x WIDTH general-purpose register bank on the CPU internal bus,
// with addressed load/inc/dec/clear, wrap flag and per-register written tracking.
// Optional feature macro BUS_REG_ZERO_R0_EN: register 0 hardwired to zero.
module bus_reg_file #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  Bus_in,
   input  logic              R_in,
   input  logic [ADDR_W-1:0] W_addr,
   input  logic [1:0]        Op,
   input  logic              R_out,
   input  logic [ADDR_W-1:0] R_addr,
   output logic [WIDTH-1:0]  Bus_out,
   output logic              Wrap,
   output logic              Uninit,
   output logic              Addr_err
);

   localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);
   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_INC  = 2'b01;
   localparam logic [1:0] OP_DEC  = 2'b10;

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] valid_eff;
   logic             w_in_range;
   logic             r_in_range;
   logic             w_en;
   logic             wrap_c;
   logic [WIDTH-1:0] w_cur;
   logic [WIDTH-1:0] w_nxt;
   logic [WIDTH-1:0] rd_data;

   assign w_in_range = ({1'b0, W_addr} < DEPTH_A);
   assign r_in_range = ({1'b0, R_addr} < DEPTH_A);

`ifdef BUS_REG_ZERO_R0_EN
   // Register 0 never accepts writes, so it stays at its reset value of zero.
   assign w_en      = R_in & w_in_range & (W_addr != '0);
   assign valid_eff = valid | {{(DEPTH-1){1'b0}}, 1'b1};
`else
   assign w_en      = R_in & w_in_range;
   assign valid_eff = valid;
`endif

   always_comb begin
      w_cur  = w_in_range ? regs[W_addr] : '0;
      w_nxt  = '0;
      wrap_c = 1'b0;
      case (Op)
         OP_LOAD: w_nxt = Bus_in;
         OP_INC: begin
            w_nxt  = w_cur + WIDTH'(1);
            wrap_c = &w_cur;
         end
         OP_DEC: begin
            w_nxt  = w_cur - WIDTH'(1);
            wrap_c = ~|w_cur;
         end
         default: w_nxt = '0;
      endcase
   end

   always_comb begin
      rd_data = '0;
      if (R_out && r_in_range) rd_data = regs[R_addr];
   end

   // Reads are pre-edge contents with no forwarding from a same-cycle write.
   assign Bus_out  = R_out ? rd_data : 'z;
   assign Uninit   = R_out & r_in_range & ~valid_eff[R_addr];
   assign Addr_err = (R_in & ~w_in_range) | (R_out & ~r_in_range);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         valid <= '0;
         Wrap  <= 1'b0;
      end else begin
         Wrap <= w_en & wrap_c;
         if (w_en) begin
            regs[W_addr]  <= w_nxt;
            valid[W_addr] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bus_reg_file.sv
// Scoreboard bench for bus_reg_file: directed scenarios plus randomized traffic
// checked against an arithmetic reference model of the register bank.
`timescale 1ns/1ps
module tb_bus_reg_file;

   localparam int WIDTH  = 32;
   localparam int DEPTH  = 6;
   localparam int ADDR_W = 3;
`ifdef BUS_REG_ZERO_R0_EN
   localparam bit ZR0 = 1'b1;
`else
   localparam bit ZR0 = 1'b0;
`endif
   localparam longint unsigned MOD = 64'd1 << WIDTH;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [WIDTH-1:0]  Bus_in = '0;
   logic              R_in = 1'b0;
   logic [ADDR_W-1:0] W_addr = '0;
   logic [1:0]        Op = 2'b00;
   logic              R_out = 1'b0;
   logic [ADDR_W-1:0] R_addr = '0;
   wire  [WIDTH-1:0]  Bus_out;
   logic              Wrap;
   logic              Uninit;
   logic              Addr_err;

   bus_reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .Bus_in(Bus_in), .R_in(R_in), .W_addr(W_addr),
      .Op(Op), .R_out(R_out), .R_addr(R_addr), .Bus_out(Bus_out), .Wrap(Wrap),
      .Uninit(Uninit), .Addr_err(Addr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] bus;
      logic             uninit;
      logic             addr_err;
      logic             wrap;
      string            tag;
   } exp_t;

   exp_t q[$];
   event sample_ev;
   int   checks = 0;
   int   errors = 0;

   longint unsigned m_reg [DEPTH];
   bit              m_valid [DEPTH];
   bit              m_wrap;

   function automatic void model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         m_reg[i]   = 0;
         m_valid[i] = 1'b0;
      end
      m_wrap = 1'b0;
   endfunction

   function automatic exp_t model_expect(string tag);
      exp_t e;
      int   ra = int'(R_addr);
      int   wa = int'(W_addr);
      e.tag = tag;
      if (!R_out)                 e.bus = 'z;
      else if (ra >= DEPTH)       e.bus = '0;
      else if (ZR0 && ra == 0)    e.bus = '0;
      else                        e.bus = WIDTH'(m_reg[ra]);
      e.uninit   = R_out && (ra < DEPTH) && !(ZR0 && ra == 0) && !m_valid[ra];
      e.addr_err = (R_in && wa >= DEPTH) || (R_out && ra >= DEPTH);
      e.wrap     = m_wrap;
      return e;
   endfunction

   function automatic void model_edge();
      int              wa = int'(W_addr);
      longint unsigned old;
      longint unsigned nv;
      m_wrap = 1'b0;
      if (R_in && wa < DEPTH && !(ZR0 && wa == 0)) begin
         old = m_reg[wa];
         case (Op)
            2'd0: nv = longint'(Bus_in);
            2'd1: begin nv = (old + 1) % MOD; m_wrap = (old + 1 == MOD); end
            2'd2: begin nv = (old + MOD - 1) % MOD; m_wrap = (old == 0); end
            default: nv = 0;
         endcase
         m_reg[wa]   = nv;
         m_valid[wa] = 1'b1;
      end
   endfunction

   task automatic push_check(string tag);
      q.push_back(model_expect(tag));
      ->sample_ev;
   endtask

   task automatic drive(input bit ri, input int wa, input int op, input logic [WIDTH-1:0] bin,
                        input bit ro, input int ra, input string tag);
      @(negedge clk);
      R_in   = ri;
      W_addr = ADDR_W'(wa);
      Op     = 2'(op);
      Bus_in = bin;
      R_out  = ro;
      R_addr = ADDR_W'(ra);
      #1;
      push_check(tag);
      @(posedge clk);
      if (reset) model_edge();
   endtask

   task automatic mid_reset(input int ra);
      @(negedge clk);
      R_in   = 1'b0;
      R_out  = 1'b1;
      R_addr = ADDR_W'(ra);
      #2;
      reset = 1'b0;
      model_clear();
      #1;
      push_check("mid_reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   always begin
      @(sample_ev);
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (Bus_out !== e.bus) begin
            errors++;
            $display("FAIL %s bus: got %h expected %h", e.tag, Bus_out, e.bus);
         end
         checks++;
         if (Uninit !== e.uninit) begin
            errors++;
            $display("FAIL %s uninit: got %b expected %b", e.tag, Uninit, e.uninit);
         end
         checks++;
         if (Addr_err !== e.addr_err) begin
            errors++;
            $display("FAIL %s addr_err: got %b expected %b", e.tag, Addr_err, e.addr_err);
         end
         checks++;
         if (Wrap !== e.wrap) begin
            errors++;
            $display("FAIL %s wrap: got %b expected %b", e.tag, Wrap, e.wrap);
         end
      end
   end

   initial begin
      logic [WIDTH-1:0] bin;
      int               sel;
      model_clear();
      reset = 1'b0;
      drive(0, 0, 0, '0, 1, 3, "in_reset");
      drive(0, 0, 0, '0, 0, 3, "in_reset_z");
      @(negedge clk);
      reset = 1'b1;

      drive(0, 0, 0, '0, 1, 3, "rst_read");
      drive(0, 0, 0, '0, 0, 3, "rst_z");

      drive(1, 2, 0, 32'd21, 0, 0, "load2");
      drive(0, 0, 0, '0, 1, 2, "read2");
      drive(1, 2, 0, 32'd9, 1, 2, "same_cycle_old");
      drive(0, 0, 0, '0, 1, 2, "same_cycle_new");

      drive(1, 5, 0, 32'hFFFFFFFF, 0, 0, "load5_ones");
      drive(1, 5, 1, '0, 1, 5, "inc5");
      drive(1, 5, 2, '0, 1, 5, "dec5_a");
      drive(1, 5, 2, '0, 1, 5, "dec5_b");
      drive(0, 0, 0, '0, 1, 5, "after_dec5");
      drive(0, 0, 0, '0, 1, 5, "wrap_clear");

      drive(1, 1, 0, 32'd7, 0, 0, "load1");
      drive(1, 1, 3, 32'd99, 1, 1, "clear1");
      for (int i = 0; i < 5; i++)
         drive(0, 1, $urandom_range(0, 3), $urandom, 1, i, "hold");

      drive(1, 7, 0, 32'd123, 1, 7, "oob_write");
      drive(1, 6, 1, '0, 1, 6, "oob_inc");
      drive(0, 0, 0, '0, 1, 2, "oob_nochange");

      drive(1, 0, 0, 32'd55, 0, 0, "load0");
      drive(0, 0, 0, '0, 1, 0, "read0");

      drive(1, 4, 0, 32'd100, 0, 0, "load4");
      drive(0, 0, 0, '0, 1, 4, "read4");
      mid_reset(4);
      drive(0, 0, 0, '0, 1, 4, "post_reset4");

      for (int n = 0; n < 500; n++) begin
         sel = $urandom_range(0, 3);
         case (sel)
            0: bin = '0;
            1: bin = '1;
            2: bin = WIDTH'($urandom_range(0, 3));
            default: bin = $urandom;
         endcase
         drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3), bin,
               $urandom_range(0, 1), $urandom_range(0, 7), "random");
         if (n == 250) mid_reset($urandom_range(0, 7));
      end

      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
